eval_timer: RTL and testbench

EVAL_TIMER -- requirements
Module: eval_timer

---
 rtl/eval_timer.sv | 98 +++++++++
 tb/tb_eval_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/eval_timer.sv
// Evaluation-window timer: counts upstream ticks against a latched budget and flags completion.
// Optional build macro EVAL_TIMER_PAUSE_EN adds a pause input that freezes counting in RUN.
module eval_timer #(
  parameter int width           = 16,
  parameter int latch_zero_done = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [width-1:0] budget,
  input  logic             abort,
  input  logic             ack,
`ifdef EVAL_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             done,
  output logic [width-1:0] elapsed,
  output logic             overrun
);

  // state | meaning
  // IDLE  | waiting for start; elapsed/overrun keep last window's values
  // RUN   | counting ticks toward the latched budget
  // DONE  | budget reached (or zero budget); waiting for ack, ticks flag overrun

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

  state_t           state;
  logic [width-1:0] remaining;
  logic             count_en;

`ifdef EVAL_TIMER_PAUSE_EN
  assign count_en = tick & ~pause;
`else
  assign count_en = tick;
`endif

  // remaining is a down-counter; a zero load wraps so it spans 2^width ticks
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      elapsed   <= '0;
      overrun   <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= budget;
            elapsed   <= '0;
            overrun   <= 1'b0;
            if (budget == '0 && latch_zero_done != 0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (count_en) begin
            elapsed   <= elapsed + one;
            remaining <= remaining - one;
            if (remaining == one) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (tick)
            overrun <= 1'b1;
          if (ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eval_timer.sv
// Randomized bench for eval_timer: a 16-bit zero-means-done instance and a 4-bit zero-means-2^width
// instance share stimulus and are compared every cycle against a tick-counting reference model.
module tb_eval_timer;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        tick   = 1'b0;
  logic        start  = 1'b0;
  logic [15:0] budget = '0;
  logic        abort  = 1'b0;
  logic        ack    = 1'b0;
  logic        pause  = 1'b0;

  logic        busy0, done0, overrun0;
  logic [15:0] elapsed0;
  logic        busy1, done1, overrun1;
  logic [3:0]  elapsed1;
  logic [3:0]  budget4;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 idle, 1 run, 2 done; counts ticks against a budget in plain integers
  int    m_state [2];
  longint m_cnt  [2];
  longint m_tgt  [2];
  int    m_over  [2];
  int    mw      [2] = '{16, 4};
  int    mlzd    [2] = '{1, 0};

  assign budget4 = budget[3:0];

  always #5 clk_in = ~clk_in;

  eval_timer #(.width(16), .latch_zero_done(1)) dut0 (
    .clk_in(clk_in), .reset(reset), .tick(tick), .start(start), .budget(budget),
    .abort(abort), .ack(ack),
`ifdef EVAL_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy0), .done(done0), .elapsed(elapsed0), .overrun(overrun0)
  );

  eval_timer #(.width(4), .latch_zero_done(0)) dut1 (
    .clk_in(clk_in), .reset(reset), .tick(tick), .start(start), .budget(budget4),
    .abort(abort), .ack(ack),
`ifdef EVAL_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy1), .done(done1), .elapsed(elapsed1), .overrun(overrun1)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    longint b;
    logic   pz;
    b  = (k == 0) ? longint'(budget) : longint'(budget4);
`ifdef EVAL_TIMER_PAUSE_EN
    pz = pause;
`else
    pz = 1'b0;
`endif
    if (reset) begin
      m_state[k] = 0; m_cnt[k] = 0; m_tgt[k] = 0; m_over[k] = 0;
    end else if (m_state[k] == 0) begin
      if (start) begin
        m_cnt[k]  = 0;
        m_over[k] = 0;
        if (b == 0 && mlzd[k] == 1) begin
          m_state[k] = 2;
        end else begin
          m_tgt[k]   = (b == 0) ? (longint'(1) << mw[k]) : b;
          m_state[k] = 1;
        end
      end
    end else if (m_state[k] == 1) begin
      if (abort) m_state[k] = 0;
      else if (tick && !pz) begin
        m_cnt[k]++;
        if (m_cnt[k] == m_tgt[k]) m_state[k] = 2;
      end
    end else begin
      if (tick) m_over[k] = 1;
      if (ack) m_state[k] = 0;
    end
  endtask

  task automatic step();
    longint mask;
    @(posedge clk_in);
    model_step(0);
    model_step(1);
    #1;
    mask = (longint'(1) << 16) - 1;
    check("busy0",    busy0,    m_state[0] == 1);
    check("done0",    done0,    m_state[0] == 2);
    check("elapsed0", elapsed0, m_cnt[0] & mask);
    check("overrun0", overrun0, m_over[0]);
    mask = (longint'(1) << 4) - 1;
    check("busy1",    busy1,    m_state[1] == 1);
    check("done1",    done1,    m_state[1] == 2);
    check("elapsed1", elapsed1, m_cnt[1] & mask);
    check("overrun1", overrun1, m_over[1]);
  endtask

  task automatic drv(input logic t, input logic s, input logic [15:0] b, input logic a, input logic k);
    tick = t; start = s; budget = b; abort = a; ack = k;
    step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    drv(0, 0, 0, 0, 0);

    // basic window: budget 3, tick every 5 cycles, then ack
    drv(0, 1, 3, 0, 0);
    for (int i = 0; i < 20; i++) drv((i % 5) == 4, 0, 16'hffff, 0, 0);
    drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);

    // start with tick in same cycle, budget 2; start during RUN ignored
    drv(1, 1, 2, 0, 0);
    drv(1, 1, 9, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1);

    // zero budget: done at once on 16-bit instance, 16 ticks on 4-bit instance
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0);

    // abort together with final tick
    drv(0, 1, 1, 0, 0);
    drv(1, 0, 0, 1, 0);
    drv(0, 0, 0, 1, 1);

    // overrun: two ticks in DONE, then a new start clears it
    drv(0, 1, 1, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0);
    drv(0, 1, 5, 0, 1);
    drv(0, 1, 1, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1);

    // reset mid-RUN with competing inputs
    drv(0, 1, 7, 0, 0);
    drv(1, 0, 0, 0, 0);
    reset = 1'b1;
    drv(1, 1, 3, 1, 1);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0);

`ifdef EVAL_TIMER_PAUSE_EN
    drv(0, 1, 2, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0);
    pause = 1'b0;
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    pause = 1'b1;
    drv(0, 0, 0, 0, 1);
    pause = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 99) < 1);
      tick   = ($urandom_range(0, 99) < 45);
      start  = ($urandom_range(0, 99) < 30);
      abort  = ($urandom_range(0, 99) < 3);
      ack    = ($urandom_range(0, 99) < 20);
      pause  = ($urandom_range(0, 99) < 15);
      budget = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
